// File: rtl/nts_api_initiator_pkg.sv
// rtl/nts_api_initiator_pkg.sv - shared encodings and constants for the NTS API initiator
// Purpose: FSM state encodings, default timeout, nts_api sub-block base addresses and
// a saturating 8-bit increment helper. No ports (package).
package nts_api_initiator_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    localparam logic [11:0] BASE_ENGINE = 12'h000;
    localparam logic [11:0] BASE_CLOCK  = 12'h010;
    localparam logic [11:0] BASE_COOKIE = 12'h020;
    localparam logic [11:0] BASE_KEYMEM = 12'h080;
    localparam logic [11:0] BASE_DEBUG  = 12'h180;
    localparam logic [11:0] BASE_PARSER = 12'h200;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/nts_api_timeout_counter.sv
// rtl/nts_api_timeout_counter.sv - saturating WAIT-state timeout counter
// Purpose: counts enabled cycles after a clear and flags the last permitted cycle.
// Ports:
//   i_clk      in  clock
//   i_areset   in  synchronous active-high reset
//   i_clear    in  reset the count to 0 (takes priority over enable)
//   i_enable   in  advance the count by one
//   o_expired  out count has reached TIMEOUT_CYCLES-1
module nts_api_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic i_clk,
    input  logic i_areset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign o_expired = (cnt_q == LAST);

    // Holds at LAST once reached so the count can never wrap back to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable && !o_expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nts_api_initiator.sv
// rtl/nts_api_initiator.sv - single-outstanding master for the nts_api register bus
// Purpose: accepts one command (valid/ready), pulses cs for one cycle, waits for
// read_data_valid or a timeout, then holds the response until taken.
// Ports:
//   i_clk, i_areset                 clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready         command handshake
//   i_cmd_we/address/write_data     command fields
//   o_rsp_valid/i_rsp_ready         response handshake
//   o_rsp_read_data/o_rsp_error     response fields (data 0 and error 1 on timeout)
//   o_api_cs/we/address/write_data  request to nts_api, fields zero when cs is low
//   i_api_read_data(_valid)         nts_api completion
//   i_api_busy                      nts_api back-pressure
//   o_busy                          FSM not idle
//   o_stray_count                   saturating count of completions outside WAIT
module nts_api_initiator
    import nts_api_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_we,
    input  logic [ADDR_WIDTH-1:0] i_cmd_address,
    input  logic [DATA_WIDTH-1:0] i_cmd_write_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_read_data,
    output logic                  o_rsp_error,
    output logic                  o_api_cs,
    output logic                  o_api_we,
    output logic [ADDR_WIDTH-1:0] o_api_address,
    output logic [DATA_WIDTH-1:0] o_api_write_data,
    input  logic [DATA_WIDTH-1:0] i_api_read_data,
    input  logic                  i_api_read_data_valid,
    input  logic                  i_api_busy,
    output logic                  o_busy,
    output logic [7:0]            o_stray_count
);

    logic [1:0]            state_q,    state_d;
    logic                  cmd_we_q,   cmd_we_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q,  rsp_err_d;
    logic [7:0]            stray_q,    stray_d;

    logic cnt_clear;
    logic cnt_enable;
    logic cnt_expired;
    logic cmd_fire;

    nts_api_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_areset  (i_areset),
        .i_clear   (cnt_clear),
        .i_enable  (cnt_enable),
        .o_expired (cnt_expired)
    );

    // Ready is also held low during reset so a command cannot appear accepted
    // on an edge where reset discards it.
    assign o_cmd_ready = (state_q == ST_IDLE) && !i_api_busy && !i_areset;
    assign cmd_fire    = i_cmd_valid && o_cmd_ready;

    assign o_api_cs         = (state_q == ST_ISSUE);
    assign o_api_we         = o_api_cs && cmd_we_q;
    assign o_api_address    = o_api_cs ? cmd_addr_q : '0;
    assign o_api_write_data = o_api_cs ? cmd_data_q : '0;

    assign o_rsp_valid     = (state_q == ST_RESP);
    assign o_rsp_read_data = rsp_data_q;
    assign o_rsp_error     = rsp_err_q;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_stray_count   = stray_q;

    always_comb begin
        state_d    = state_q;
        cmd_we_d   = cmd_we_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        stray_d    = stray_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    cmd_we_d   = i_cmd_we;
                    cmd_addr_d = i_cmd_address;
                    cmd_data_d = i_cmd_write_data;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_clear = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_enable = 1'b1;
                // A completion on the last permitted cycle still counts as success.
                if (i_api_read_data_valid) begin
                    rsp_data_d = i_api_read_data;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (cnt_expired) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_api_read_data_valid && (state_q != ST_WAIT)) begin
            stray_d = sat_inc8(stray_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state_q    <= ST_IDLE;
            cmd_we_q   <= 1'b0;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            stray_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            cmd_we_q   <= cmd_we_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            stray_q    <= stray_d;
        end
    end

endmodule

// File: tb/tb_nts_api_initiator.sv
// tb/tb_nts_api_initiator.sv - self-checking bench for nts_api_initiator
module tb_nts_api_initiator;

    localparam int TMO = 8;

    logic        clk;
    logic        i_areset;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_we;
    logic [11:0] i_cmd_address;
    logic [31:0] i_cmd_write_data;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_read_data;
    logic        o_rsp_error;
    logic        o_api_cs;
    logic        o_api_we;
    logic [11:0] o_api_address;
    logic [31:0] o_api_write_data;
    logic [31:0] i_api_read_data;
    logic        i_api_read_data_valid;
    logic        i_api_busy;
    logic        o_busy;
    logic [7:0]  o_stray_count;

    int checks = 0;
    int errors = 0;
    int exp_stray = 0;
    logic [31:0] ref_mem [0:4095];
    logic [31:0] api_mem [0:4095];

    nts_api_initiator #(
        .ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk                 (clk),
        .i_areset              (i_areset),
        .i_cmd_valid           (i_cmd_valid),
        .o_cmd_ready           (o_cmd_ready),
        .i_cmd_we              (i_cmd_we),
        .i_cmd_address         (i_cmd_address),
        .i_cmd_write_data      (i_cmd_write_data),
        .o_rsp_valid           (o_rsp_valid),
        .i_rsp_ready           (i_rsp_ready),
        .o_rsp_read_data       (o_rsp_read_data),
        .o_rsp_error           (o_rsp_error),
        .o_api_cs              (o_api_cs),
        .o_api_we              (o_api_we),
        .o_api_address         (o_api_address),
        .o_api_write_data      (o_api_write_data),
        .i_api_read_data       (i_api_read_data),
        .i_api_read_data_valid (i_api_read_data_valid),
        .i_api_busy            (i_api_busy),
        .o_busy                (o_busy),
        .o_stray_count         (o_stray_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction. delay: WAIT cycle (0-based) carrying the completion,
    // -1 for none. wret: value nts_api returns on a write. busy_cyc: cycles of busy
    // before acceptance. stray_issue: completion pulse in the cs cycle. hold: cycles
    // the response is left waiting.
    task automatic do_txn(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                          input int delay, input logic [31:0] wret, input int busy_cyc,
                          input bit stray_issue, input int hold);
        int k, guard, cs_cnt, lat, exp_lat;
        bit bus_clean, busy_ok, seen, held_ok, st;
        logic cs_we, got_err, exp_err;
        logic [11:0] cs_addr;
        logic [31:0] cs_data, ret, got_data, exp_data;

        exp_err  = (delay < 0);
        exp_data = exp_err ? 32'h0 : (we ? wret : ref_mem[addr]);
        exp_lat  = exp_err ? TMO + 1 : delay + 2;
        if (we) ref_mem[addr] = wdata;

        @(posedge clk); #1;
        i_cmd_valid = 1'b1; i_cmd_we = we; i_cmd_address = addr; i_cmd_write_data = wdata;
        busy_ok = 1'b1;
        i_api_busy = (busy_cyc > 0);
        for (int b = 0; b < busy_cyc; b++) begin
            @(negedge clk);
            if (o_cmd_ready !== 1'b0 || o_api_cs !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
        i_api_busy = 1'b0;
        if (busy_cyc > 0) check("busy_backoff", busy_ok, 1);
        guard = 0;
        @(negedge clk);
        while (o_cmd_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1; @(negedge clk); guard++;
        end
        check("accept_first_cycle", guard, 0);
        @(posedge clk); #1;
        i_cmd_valid = 1'b0; i_cmd_we = 1'($urandom);
        i_cmd_address = 12'($urandom); i_cmd_write_data = $urandom;

        k = 0; cs_cnt = 0; seen = 1'b0; bus_clean = 1'b1; ret = 32'h0; lat = -1;
        cs_we = 1'b0; cs_addr = 12'h0; cs_data = 32'h0; got_data = 32'h0; got_err = 1'b0;
        while (!seen && k < TMO + 6) begin
            i_api_read_data_valid = (k == 0 && stray_issue) || (delay >= 0 && k == delay + 1);
            i_api_read_data = (delay >= 0 && k == delay + 1) ? ret : $urandom;
            if (k == 0 && stray_issue) exp_stray = sat(exp_stray + 1);
            @(negedge clk);
            if (o_api_cs === 1'b1) begin
                cs_cnt++;
                cs_we = o_api_we; cs_addr = o_api_address; cs_data = o_api_write_data;
                if (o_api_we) begin
                    api_mem[o_api_address] = o_api_write_data;
                    ret = wret;
                end else begin
                    ret = api_mem[o_api_address];
                end
            end else if (o_api_we !== 1'b0 || o_api_address !== 12'h0 || o_api_write_data !== 32'h0) begin
                bus_clean = 1'b0;
            end
            if (o_rsp_valid === 1'b1) begin
                seen = 1'b1; got_data = o_rsp_read_data; got_err = o_rsp_error; lat = k;
            end else begin
                @(posedge clk); #1; k++;
            end
        end
        i_api_read_data_valid = 1'b0;

        check("cs_count", cs_cnt, 1);
        check("cs_we", cs_we, we);
        check("cs_addr", cs_addr, addr);
        check("cs_wdata", cs_data, wdata);
        check("bus_zero_without_cs", bus_clean, 1);
        check("rsp_seen", seen, 1);
        check("rsp_latency", lat, exp_lat);
        check("rsp_data", got_data, exp_data);
        check("rsp_error", got_err, exp_err);

        held_ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            i_cmd_valid = 1'b1; i_cmd_address = 12'($urandom); i_cmd_we = 1'($urandom);
            st = 1'($urandom_range(0, 1));
            i_api_read_data_valid = st; i_api_read_data = $urandom;
            if (st) exp_stray = sat(exp_stray + 1);
            @(negedge clk);
            if (o_rsp_valid !== 1'b1 || o_rsp_read_data !== got_data || o_rsp_error !== got_err ||
                o_cmd_ready !== 1'b0 || o_api_cs !== 1'b0) held_ok = 1'b0;
        end
        if (hold > 0) check("rsp_held", held_ok, 1);
        @(posedge clk); #1;
        i_cmd_valid = 1'b0; i_api_read_data_valid = 1'b0; i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        i_rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_dropped", o_rsp_valid, 0);
        check("idle_after_rsp", o_busy, 0);
        check("stray_count", o_stray_count, exp_stray);
    endtask

    initial begin
        i_areset = 1'b1; i_cmd_valid = 1'b0; i_cmd_we = 1'b0; i_cmd_address = 12'h0;
        i_cmd_write_data = 32'h0; i_rsp_ready = 1'b0; i_api_read_data = 32'h0;
        i_api_read_data_valid = 1'b0; i_api_busy = 1'b0;
        for (int a = 0; a < 4096; a++) begin
            ref_mem[a] = 32'h0; api_mem[a] = 32'h0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", o_cmd_ready, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_cs", o_api_cs, 0);
        check("rst_busy", o_busy, 0);
        check("rst_stray", o_stray_count, 0);
        check("rst_rsp_data", {o_rsp_error, o_rsp_read_data}, 0);
        @(posedge clk); #1; i_areset = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", o_cmd_ready, 1);

        // Stray completion in IDLE
        @(posedge clk); #1; i_api_read_data_valid = 1'b1; i_api_read_data = 32'hDEAD_BEEF;
        @(posedge clk); #1; i_api_read_data_valid = 1'b0;
        exp_stray = 1;
        @(negedge clk);
        check("stray_idle_count", o_stray_count, 1);
        check("stray_idle_no_rsp", o_rsp_valid, 0);
        check("stray_idle_not_busy", o_busy, 0);

        // Directed transactions
        ref_mem[12'h005] = 32'h0A00_0005; api_mem[12'h005] = 32'h0A00_0005;
        do_txn(1'b0, 12'h005, 32'h0, 0, 32'h0, 0, 1'b0, 0);
        do_txn(1'b1, 12'h082, 32'hE, 0, 32'h0, 0, 1'b0, 1);
        do_txn(1'b0, 12'h010, 32'h0, 1, 32'h0, 5, 1'b0, 0);
        do_txn(1'b0, 12'h020, 32'h0, -1, 32'h0, 0, 1'b0, 0);
        ref_mem[12'h020] = 32'hC00C_1E20; api_mem[12'h020] = 32'hC00C_1E20;
        do_txn(1'b0, 12'h020, 32'h0, TMO - 1, 32'h0, 0, 1'b0, 0);
        do_txn(1'b0, 12'h180, 32'h0, 2, 32'h0, 0, 1'b1, 2);

        // Parser block fill and read-back
        for (int i = 0; i < 256; i++) begin
            do_txn(1'b1, 12'(12'h200 + i), 32'h7FFF_FFFF + 32'(17 * i),
                   int'($urandom_range(0, 3)), $urandom, 0, 1'b0, 0);
        end
        for (int i = 0; i < 256; i++) begin
            do_txn(1'b0, 12'(12'h200 + i), $urandom, int'($urandom_range(0, 3)),
                   32'h0, 0, 1'b0, 0);
        end
        check("parser_last_word", ref_mem[12'h2FF], 32'h7FFF_FFFF + 32'(17 * 255));

        // Randomised mix
        for (int n = 0; n < 120; n++) begin
            do_txn(1'($urandom), 12'(12'h080 + $urandom_range(0, 15)), $urandom,
                   int'($urandom_range(0, TMO)) - 1, $urandom, int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Stray counter saturation
        @(posedge clk); #1; i_api_read_data_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1; i_api_read_data_valid = 1'b0;
        exp_stray = sat(exp_stray + 300);
        @(negedge clk);
        check("stray_saturates", o_stray_count, exp_stray);

        // Reset while waiting for a completion
        @(posedge clk); #1;
        i_cmd_valid = 1'b1; i_cmd_we = 1'b0; i_cmd_address = 12'h010;
        @(negedge clk);
        check("rst_test_ready", o_cmd_ready, 1);
        @(posedge clk); #1; i_cmd_valid = 1'b0;
        @(posedge clk); #1; i_areset = 1'b1;
        @(negedge clk);
        check("rst_test_in_wait", o_busy, 1);
        @(posedge clk); #1; i_areset = 1'b0; exp_stray = 0;
        @(negedge clk);
        check("rst_mid_busy", o_busy, 0);
        check("rst_mid_rsp_valid", o_rsp_valid, 0);
        check("rst_mid_cs", o_api_cs, 0);
        check("rst_mid_stray", o_stray_count, 0);
        @(posedge clk); #1; i_api_read_data_valid = 1'b1;
        @(posedge clk); #1; i_api_read_data_valid = 1'b0;
        exp_stray = 1;
        @(negedge clk);
        check("late_valid_is_stray", o_stray_count, exp_stray);
        check("late_valid_no_rsp", o_rsp_valid, 0);
        repeat (3) @(negedge clk);
        check("no_rsp_after_reset", o_rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
